// File: rtl/card_pkg.sv
// Shared card types and scoring helpers for the baccarat card dealer.
package card_pkg;

    typedef logic [3:0] rank_t;

    localparam rank_t RANK_EMPTY = 4'd0;
    localparam rank_t RANK_K     = 4'd13;
    localparam int    NUM_RANKS  = 13;

    // Baccarat value of a rank: A-9 count face value, 10-K and empty count 0.
    function automatic logic [3:0] card_value(input rank_t rank);
        return (rank >= 4'd1 && rank <= 4'd9) ? rank : 4'd0;
    endfunction

    function automatic logic [3:0] mod10_sum3(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {1'b0, c};
        if (sum >= 5'd20) begin
            sum = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end
        return sum[3:0];
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1, restarting from SEED on reset.
module card_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       slow_clock,
    input  logic       reset,
    output logic [7:0] q
);

    localparam logic [7:0] TAPS = 8'hB8;

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[7:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ TAPS;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// Draws cards into six slots on the controller's load strobes and scores both hands.
// CARD_DEALER_SHOE_TRACK_EN selects a finite shoe; otherwise cards are drawn with replacement.
module card_dealer
    import card_pkg::*;
#(
    parameter int         NUM_DECKS = 1,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output rank_t      pcard1,
    output rank_t      pcard2,
    output rank_t      pcard3_rank,
    output rank_t      dcard1,
    output rank_t      dcard2,
    output rank_t      dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [3:0] pcard3,
    output logic [7:0] cards_left,
    output logic       reshuffled
);

    localparam logic [7:0] SHOE_SIZE = 8'(52 * NUM_DECKS);

    logic [7:0] lfsr;
    logic [3:0] cand;
    logic       any_load;
    rank_t      draw_rank;

    rank_t pcard1_q, pcard2_q, pcard3_q, dcard1_q, dcard2_q, dcard3_q;
    rank_t pcard1_d, pcard2_d, pcard3_d, dcard1_d, dcard2_d, dcard3_d;

    card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .slow_clock(slow_clock),
        .reset     (reset),
        .q         (lfsr)
    );

    assign any_load = load_pcard1 | load_pcard2 | load_pcard3 |
                      load_dcard1 | load_dcard2 | load_dcard3;
    assign cand     = 4'(lfsr % 8'd13);

`ifdef CARD_DEALER_SHOE_TRACK_EN
    localparam logic [4:0] PER_RANK = 5'(4 * NUM_DECKS);

    logic [4:0] count_q [NUM_RANKS];
    logic [4:0] count_d [NUM_RANKS];
    logic [4:0] avail   [NUM_RANKS];
    logic [7:0] cards_left_q, cards_left_d;
    logic       reshuffled_q;
    logic       refill;
    logic       found;
    logic [3:0] pick;
    logic [3:0] scan_idx;
    logic [4:0] scan_sum;

    // An empty shoe is refilled and drawn from on the same edge.
    always_comb begin
        refill   = any_load && (cards_left_q == 8'd0);
        pick     = cand;
        found    = 1'b0;
        scan_sum = 5'd0;
        scan_idx = cand;
        for (int r = 0; r < NUM_RANKS; r++) begin
            avail[r] = refill ? PER_RANK : count_q[r];
        end
        for (int off = 0; off < NUM_RANKS; off++) begin
            scan_sum = 5'(cand) + 5'(off);
            scan_idx = (scan_sum >= 5'd13) ? 4'(scan_sum - 5'd13) : scan_sum[3:0];
            if (!found && avail[scan_idx] != 5'd0) begin
                pick  = scan_idx;
                found = 1'b1;
            end
        end
        count_d      = avail;
        cards_left_d = cards_left_q;
        if (any_load) begin
            count_d[pick] = avail[pick] - 5'd1;
            cards_left_d  = (refill ? SHOE_SIZE : cards_left_q) - 8'd1;
        end
    end

    // NOTE: the rank counters are plain flops and must be reset so a reset refills the shoe.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                count_q[r] <= PER_RANK;
            end
            cards_left_q <= SHOE_SIZE;
            reshuffled_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            cards_left_q <= cards_left_d;
            reshuffled_q <= refill;
        end
    end

    assign draw_rank  = pick + 4'd1;
    assign cards_left = cards_left_q;
    assign reshuffled = reshuffled_q;
`else
    assign draw_rank  = cand + 4'd1;
    assign cards_left = SHOE_SIZE;
    assign reshuffled = 1'b0;
`endif

    // NOTE: hold values are assigned first so no path through always_comb infers a latch.
    always_comb begin
        pcard1_d = pcard1_q;
        pcard2_d = pcard2_q;
        pcard3_d = pcard3_q;
        dcard1_d = dcard1_q;
        dcard2_d = dcard2_q;
        dcard3_d = dcard3_q;
        if (load_pcard1) begin
            pcard1_d = draw_rank;
            pcard2_d = RANK_EMPTY;
            pcard3_d = RANK_EMPTY;
            dcard1_d = RANK_EMPTY;
            dcard2_d = RANK_EMPTY;
            dcard3_d = RANK_EMPTY;
        end else if (load_pcard2) begin
            pcard2_d = draw_rank;
        end else if (load_pcard3) begin
            pcard3_d = draw_rank;
        end else if (load_dcard1) begin
            dcard1_d = draw_rank;
        end else if (load_dcard2) begin
            dcard2_d = draw_rank;
        end else if (load_dcard3) begin
            dcard3_d = draw_rank;
        end
    end

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            pcard1_q <= RANK_EMPTY;
            pcard2_q <= RANK_EMPTY;
            pcard3_q <= RANK_EMPTY;
            dcard1_q <= RANK_EMPTY;
            dcard2_q <= RANK_EMPTY;
            dcard3_q <= RANK_EMPTY;
        end else begin
            pcard1_q <= pcard1_d;
            pcard2_q <= pcard2_d;
            pcard3_q <= pcard3_d;
            dcard1_q <= dcard1_d;
            dcard2_q <= dcard2_d;
            dcard3_q <= dcard3_d;
        end
    end

    assign pcard1      = pcard1_q;
    assign pcard2      = pcard2_q;
    assign pcard3_rank = pcard3_q;
    assign dcard1      = dcard1_q;
    assign dcard2      = dcard2_q;
    assign dcard3      = dcard3_q;

    assign pscore = mod10_sum3(card_value(pcard1_q), card_value(pcard2_q), card_value(pcard3_q));
    assign dscore = mod10_sum3(card_value(dcard1_q), card_value(dcard2_q), card_value(dcard3_q));
    assign pcard3 = card_value(pcard3_q);

endmodule
